// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [3:0] BE_BYTE = 4'h1;
  localparam logic [3:0] BE_HALF = 4'h3;
  localparam logic [3:0] BE_WORD = 4'hF;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/dm_grant_sel.sv
// Combinational grant resolution: lock owner first, then starve guard, then fixed priority.
module dm_grant_sel
  import dm_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t owner,
  input  logic   starve_hit,
  output logic   gnt0,
  output logic   gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner == OWN_P0 && req0) begin
      gnt0 = 1'b1;
    end else if (owner == OWN_P1 && req1) begin
      gnt1 = 1'b1;
    end else if (req1 && starve_hit && owner != OWN_P0) begin
      gnt1 = 1'b1;
    end else if (req0 && owner != OWN_P1) begin
      gnt0 = 1'b1;
    end else if (req1 && owner != OWN_P0) begin
      gnt1 = 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-ported data memory, with lock ownership,
// a starvation guard for port 1 and registered ack/read data.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [DW-1:0]     wdata0,
  input  logic [DW-1:0]     wdata1,
  input  logic [DW/8-1:0]   be0,
  input  logic [DW/8-1:0]   be1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DW-1:0]     rdata0,
  output logic [DW-1:0]     rdata1,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_din,
  output logic              m_we,
  output logic [DW/8-1:0]   m_wbit,
  input  logic [DW-1:0]     m_dout
);

  localparam int unsigned BW = DW / 8;
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_t              owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_hit;
  logic                sel_gnt0, sel_gnt1;
  logic                sel_we;
  logic [BW-1:0]       sel_be;
  logic [DW-1:0]       sel_wd;
  int unsigned         src;

  assign starve_hit = (starve_cnt == LIMIT);

  dm_grant_sel u_grant_sel (
    .req0       (req0),
    .req1       (req1),
    .owner      (owner),
    .starve_hit (starve_hit),
    .gnt0       (sel_gnt0),
    .gnt1       (sel_gnt1)
  );

  assign gnt0 = sel_gnt0 & rst_n;
  assign gnt1 = sel_gnt1 & rst_n;

  // Requesters pack enabled bytes from bit 0; spread them onto their lanes here.
  always_comb begin
    sel_we = 1'b0;
    sel_be = '0;
    sel_wd = '0;
    m_addr = addr0;
    if (gnt0) begin
      sel_we = we0;
      sel_be = be0;
      sel_wd = wdata0;
    end else if (gnt1) begin
      sel_we = we1;
      sel_be = be1;
      sel_wd = wdata1;
      m_addr = addr1;
    end
    m_din = '0;
    src   = 0;
    for (int unsigned k = 0; k < BW; k++) begin
      if (sel_be[k]) begin
        m_din[8*k +: 8] = sel_wd[8*src +: 8];
        src = src + 1;
      end
    end
    m_wbit = sel_be;
    m_we   = sel_we & (|sel_be);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      ack0 <= gnt0;
      ack1 <= gnt1;
      if (gnt0 && !we0) rdata0 <= m_dout;
      if (gnt1 && !we1) rdata1 <= m_dout;

      if (!req1 || gnt1) starve_cnt <= '0;
      else if (!starve_hit) starve_cnt <= starve_cnt + 1'b1;

      if (gnt0 && lock0) begin
        owner <= OWN_P0;
      end else if (gnt1 && lock1) begin
        owner <= OWN_P1;
      end else if ((owner == OWN_P0 && (gnt0 || !req0)) ||
                   (owner == OWN_P1 && (gnt1 || !req1))) begin
        owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural byte-lane memory model.
module tb_dm_port_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  m_addr;
  logic [31:0] m_din;
  logic        m_we;
  logic [3:0]  m_wbit;
  logic [31:0] m_dout;

  logic [31:0] mem [0:1023];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_wbit(m_wbit), .m_dout(m_dout)
  );

  assign m_dout = mem[m_addr];

  always @(posedge clk) begin
    if (m_we) begin
      for (int k = 0; k < 4; k++)
        if (m_wbit[k]) mem[m_addr][8*k +: 8] <= m_din[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst_n = 1'b0;
    {req0, req1, we0, we1, lock0, lock1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
    tick; tick;

    // Reset with an active write request
    req0 = 1; we0 = 1; be0 = BE_WORD; addr0 = 10'h005; wdata0 = 32'h12345678;
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    tick;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_owner", 32'(dut.owner), 32'(OWN_NONE));
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_mem", mem[5], 32'd0);
    req0 = 0; we0 = 0; rst_n = 1;
    tick;

    // Idle memory-side defaults
    addr0 = 10'h155; addr1 = 10'h2AA;
    #1;
    check("idle_m_addr", 32'(m_addr), 32'h155);
    check("idle_m_din", m_din, 32'd0);
    check("idle_m_wbit", 32'(m_wbit), 32'd0);

    // Contention: four port-0 grants, then the starve guard lets port 1 in
    req0 = 1; we0 = 0; addr0 = 10'h000; be0 = BE_WORD;
    req1 = 1; we1 = 0; addr1 = 10'h001; be1 = BE_WORD;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_gnt0_%0d", i), 32'(gnt0), 32'd1);
      check($sformatf("cont_gnt1_%0d", i), 32'(gnt1), 32'd0);
      tick;
    end
    check("cont_starve_full", 32'(dut.starve_cnt), 32'd4);
    #1;
    check("cont_gnt1_5th", 32'(gnt1), 32'd1);
    check("cont_gnt0_5th", 32'(gnt0), 32'd0);
    tick;
    check("cont_ack1", 32'(ack1), 32'd1);
    check("cont_starve_clr", 32'(dut.starve_cnt), 32'd0);
    req0 = 0; req1 = 0;
    tick;

    // Lock: port 1 holds ownership for three locked grants plus the releasing one
    req1 = 1; lock1 = 1; addr1 = 10'h002;
    #1;
    check("lock_first_gnt1", 32'(gnt1), 32'd1);
    tick;
    check("lock_owner_p1", 32'(dut.owner), 32'(OWN_P1));
    req0 = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) lock1 = 0;
      #1;
      check($sformatf("lock_gnt1_%0d", i), 32'(gnt1), 32'd1);
      check($sformatf("lock_gnt0_%0d", i), 32'(gnt0), 32'd0);
      tick;
    end
    req1 = 0;
    #1;
    check("lock_release_gnt0", 32'(gnt0), 32'd1);
    tick;
    req0 = 0;
    check("lock_owner_none", 32'(dut.owner), 32'(OWN_NONE));

    // Byte write with packed lanes, then read back
    req0 = 1; we0 = 1; addr0 = 10'h004; be0 = 4'h6; wdata0 = 32'h0000BBAA;
    #1;
    check("bw_gnt0", 32'(gnt0), 32'd1);
    check("bw_m_we", 32'(m_we), 32'd1);
    check("bw_m_wbit", 32'(m_wbit), 32'h6);
    check("bw_m_din", m_din, 32'h00BBAA00);
    tick;
    check("bw_ack0", 32'(ack0), 32'd1);
    we0 = 0; be0 = BE_WORD;
    tick;
    check("bw_rd_ack0", 32'(ack0), 32'd1);
    check("bw_rdata0", rdata0, 32'h00BBAA00);
    req0 = 0;
    tick;
    check("bw_ack0_pulse", 32'(ack0), 32'd0);
    check("bw_rdata0_hold", rdata0, 32'h00BBAA00);

    // Read-after-write across ports
    req1 = 1; we1 = 1; addr1 = 10'h3FF; be1 = BE_WORD; wdata1 = 32'hDEADBEEF;
    #1;
    check("raw_gnt1", 32'(gnt1), 32'd1);
    check("raw_m_addr", 32'(m_addr), 32'h3FF);
    tick;
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 10'h3FF;
    tick;
    check("raw_ack0", 32'(ack0), 32'd1);
    check("raw_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick;

    // Write with no byte enables is granted and acked but leaves memory alone
    req1 = 1; we1 = 1; addr1 = 10'h3FF; be1 = 4'h0; wdata1 = 32'h12345678;
    #1;
    check("be0_gnt1", 32'(gnt1), 32'd1);
    check("be0_m_we", 32'(m_we), 32'd0);
    tick;
    req1 = 0; we1 = 0;
    check("be0_ack1", 32'(ack1), 32'd1);
    check("be0_mem", mem[10'h3FF], 32'hDEADBEEF);

    // Reset while port 1 owns a lock
    req1 = 1; lock1 = 1; we1 = 1; be1 = BE_WORD; addr1 = 10'h010; wdata1 = 32'hCAFEF00D;
    tick;
    check("rl_owner_p1", 32'(dut.owner), 32'(OWN_P1));
    rst_n = 0;
    #1;
    check("rl_gnt1", 32'(gnt1), 32'd0);
    check("rl_m_we", 32'(m_we), 32'd0);
    tick;
    check("rl_owner_none", 32'(dut.owner), 32'(OWN_NONE));
    rst_n = 1; req1 = 0; lock1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 10'h010;
    #1;
    check("rl_gnt0_after", 32'(gnt0), 32'd1);
    tick;
    check("rl_rdata0", rdata0, 32'hCAFEF00D);
    req0 = 0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
